pred_reg_file_p: RTL and testbench
==================================

PRED_REG_FILE_P -- requirements
Module: pred_reg_file_p

Interface
REQ-001 Parameter PW, default 4: predicate width in bits.
REQ-002 Parameter DEPTH, default 64: number of entries, power of two, minimum 2; AW = clog2(DEPTH).
REQ-003 Parameter NCH, default 5: neighbour channels (0..3 = edges, 4 = bus); SW = clog2(NCH+1).
REQ-004 CLK  in  1  clock; all state updates on rising edge.
REQ-005 RST_N  in  1  reset; asynchronous, active-low.
REQ-006 ch_in  in  NCH*PW  incoming predicates; channel k occupies bits [k*PW +: PW].
REQ-007 ch_sel  in  SW  capture select: 0 = none, k = channel k-1.
REQ-008 ch_addr  in  AW  capture write address.
REQ-009 wb_en / wb_addr / wb_data  in  1 / AW / PW  FU write-back.
REQ-010 rd_src  in  SW  FU source: 0 = file, k = channel k-1 direct.
REQ-011 rd_addr  in  AW  FU file read address.
REQ-012 pred_out / pred_vld  out  PW / 1  predicate to FU and its valid flag.
REQ-013 snd_addr / snd_mask  in  AW / NCH  send address and per-channel enable mask.
REQ-014 ch_out  out  NCH*PW  registered outgoing predicates.
REQ-015 clr  in  1  synchronous clear of all valid bits.
REQ-016 occ / coll  out  AW+1 / 1  count of valid entries; sticky collision flag.

Function
REQ-017 Each entry SHALL hold PW data bits plus one valid bit.
REQ-018 ch_sel in 1..NCH SHALL write the selected channel to ch_addr and set its valid bit; ch_sel > NCH SHALL write nothing.
REQ-019 wb_en=1 SHALL write wb_data to wb_addr and set its valid bit.
REQ-020 Both writes to the same address in one cycle: write-back SHALL win; coll SHALL set and stay set until reset.
REQ-021 Writes to different addresses in one cycle SHALL both take effect.
REQ-022 rd_src=0: pred_out = entry[rd_addr] data and pred_vld = its valid bit, combinationally; no bypass unless REQ-033 applies.
REQ-023 rd_src in 1..NCH: pred_out = that channel's input and pred_vld=1; rd_src > NCH: pred_out=0, pred_vld=0.
REQ-024 ch_out lane k SHALL load entry[snd_addr] data one cycle after snd_mask[k]=1, and SHALL load 0 when snd_mask[k]=0.
REQ-025 Sending an invalid entry SHALL drive 0 on the lane.
REQ-026 occ SHALL increment once per entry whose valid bit goes 0->1; a same-address collision counts once; re-writing a valid entry SHALL not change occ.
REQ-027 occ SHALL saturate at DEPTH and SHALL never wrap.
REQ-028 clr=1 SHALL clear all valid bits and set occ to 0; any write in the same cycle SHALL be discarded (clr wins).
REQ-029 Entry data SHALL be retained across clr; only the valid bits are cleared.

Reset
REQ-030 RST_N=0 SHALL immediately clear all valid bits, occ=0, coll=0, and all ch_out lanes=0, independent of CLK.
REQ-031 Entry data SHALL be unaffected by reset; it is unreadable until rewritten because its valid bit is 0.
REQ-032 Writes in the first CLK edge after RST_N rises SHALL take effect normally.

Configuration
REQ-033 With PRED_BYPASS_EN defined: when rd_src=0 and rd_addr matches an address being written this cycle, pred_out/pred_vld SHALL show the winning write data with valid=1. The same SHALL apply to ch_out on a snd_addr match, so ch_out carries the new value next cycle. Without PRED_BYPASS_EN, the pre-write contents SHALL be returned.

Structure
REQ-034 A shared package pred_pkg SHALL hold the select encodings (SEL_NONE=0, channel base=1), default PW/DEPTH/NCH, and a pred_t typedef.
REQ-035 The send path SHALL be one sub-module, pred_send_lane, instantiated NCH times.

Verification
REQ-036 Reset, then rd_src=0, rd_addr=5 -> pred_vld=0, occ=0, ch_out all 0.
REQ-037 ch_sel=2 (ch1=4'hA), ch_addr=7, then snd_addr=7, snd_mask=5'b10001 -> next cycle lanes 0 and 4 = 4'hA, others 0; occ=1.
REQ-038 ch_sel=1 (ch0=4'h3) and wb_en with wb_data=4'hC, both to address 9 -> entry 9 = 4'hC, coll=1, occ=1.
REQ-039 Fill all 64 addresses, then write address 0 again -> occ=64 and stays 64.
REQ-040 clr together with wb_en to address 3 -> occ=0, entry 3 invalid; reading entry 3 after a later rewrite returns the rewritten data.
REQ-041 wb_en to address 4 (4'h6) with rd_addr=4 in the same cycle -> pred_out=4'h6 with PRED_BYPASS_EN, old contents without it.

Source files
------------

// File: rtl/pred_pkg.sv
// Shared encodings and default sizes for the predicate register file.
package pred_pkg;
   localparam int PW_DEF      = 4;
   localparam int DEPTH_DEF   = 64;
   localparam int NCH_DEF     = 5;
   localparam int SEL_NONE    = 0;
   localparam int SEL_CH_BASE = 1;

   typedef logic [PW_DEF-1:0] pred_t;
endpackage

// File: rtl/pred_reg_file_p_if.sv
// Bus bundle for pred_reg_file_p: capture, write-back, FU read, send and status.
interface pred_reg_file_p_if #(
   parameter int PW    = 4,
   parameter int DEPTH = 64,
   parameter int NCH   = 5
) ();
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(NCH + 1);

   logic [NCH*PW-1:0] ch_in;
   logic [SW-1:0]     ch_sel;
   logic [AW-1:0]     ch_addr;
   logic              wb_en;
   logic [AW-1:0]     wb_addr;
   logic [PW-1:0]     wb_data;
   logic [SW-1:0]     rd_src;
   logic [AW-1:0]     rd_addr;
   logic [PW-1:0]     pred_out;
   logic              pred_vld;
   logic [AW-1:0]     snd_addr;
   logic [NCH-1:0]    snd_mask;
   logic [NCH*PW-1:0] ch_out;
   logic              clr;
   logic [AW:0]       occ;
   logic              coll;

   modport master (
      output ch_in, ch_sel, ch_addr, wb_en, wb_addr, wb_data,
             rd_src, rd_addr, snd_addr, snd_mask, clr,
      input  pred_out, pred_vld, ch_out, occ, coll
   );

   modport slave (
      input  ch_in, ch_sel, ch_addr, wb_en, wb_addr, wb_data,
             rd_src, rd_addr, snd_addr, snd_mask, clr,
      output pred_out, pred_vld, ch_out, occ, coll
   );
endinterface

// File: rtl/pred_send_lane.sv
// One registered outgoing predicate lane; loads the send value when enabled, else 0.
module pred_send_lane
   import pred_pkg::*;
#(
   parameter int PW = PW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [PW-1:0] data,
   output logic [PW-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= en ? data : '0;
   end
endmodule

// File: rtl/pred_reg_file_p.sv
// Predicate register file with neighbour capture, FU write-back, direct channel reads and send lanes.
// Optional same-cycle write bypass on the read and send paths: define PRED_BYPASS_EN.
module pred_reg_file_p
   import pred_pkg::*;
#(
   parameter int PW    = PW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int NCH   = NCH_DEF
) (
   input logic             clk,
   input logic             rst_n,
   pred_reg_file_p_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(NCH + 1);
   localparam logic [SW-1:0] SEL_NONE_S = SW'(SEL_NONE);
   localparam logic [SW-1:0] SEL_BASE_S = SW'(SEL_CH_BASE);

   // Data carries no reset: an entry is only meaningful while its valid bit is set.
   logic [PW-1:0]     mem [DEPTH];
   logic [DEPTH-1:0]  vld;
   logic              cap_en;
   logic [PW-1:0]     cap_data;
   logic              hit;
   logic [1:0]        inc;
   logic [AW+1:0]     occ_sum;
   logic [AW:0]       occ_q;
   logic              coll_q;
   logic [PW-1:0]     rd_data;
   logic              rd_vld;
   logic [PW-1:0]     snd_data;
   logic [NCH*PW-1:0] ch_out_q;

   always_comb begin
      cap_en   = 1'b0;
      cap_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (bus.ch_sel == SW'(k) + SEL_BASE_S) begin
            cap_en   = 1'b1;
            cap_data = bus.ch_in[k*PW +: PW];
         end
      end
   end

   // A same-address collision is one newly valid entry, credited to the capture term.
   assign hit     = cap_en & bus.wb_en & (bus.ch_addr == bus.wb_addr);
   assign inc     = 2'(cap_en & ~vld[bus.ch_addr]) +
                    2'(bus.wb_en & ~vld[bus.wb_addr] & ~hit);
   assign occ_sum = {1'b0, occ_q} + (AW+2)'(inc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld    <= '0;
         occ_q  <= '0;
         coll_q <= 1'b0;
      end else if (bus.clr) begin
         vld   <= '0;
         occ_q <= '0;
      end else begin
         if (cap_en)    vld[bus.ch_addr] <= 1'b1;
         if (bus.wb_en) vld[bus.wb_addr] <= 1'b1;
         if (hit)       coll_q           <= 1'b1;
         occ_q <= (occ_sum > (AW+2)'(DEPTH)) ? (AW+1)'(DEPTH) : occ_sum[AW:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!bus.clr) begin
         if (cap_en && !hit) mem[bus.ch_addr] <= cap_data;
         if (bus.wb_en)      mem[bus.wb_addr] <= bus.wb_data;
      end
   end

   always_comb begin
      rd_data  = mem[bus.rd_addr];
      rd_vld   = vld[bus.rd_addr];
      snd_data = vld[bus.snd_addr] ? mem[bus.snd_addr] : '0;
`ifdef PRED_BYPASS_EN
      // Write-back is applied last so it overrides a capture to the same address.
      if (!bus.clr) begin
         if (cap_en && bus.ch_addr == bus.rd_addr) begin
            rd_data = cap_data;
            rd_vld  = 1'b1;
         end
         if (bus.wb_en && bus.wb_addr == bus.rd_addr) begin
            rd_data = bus.wb_data;
            rd_vld  = 1'b1;
         end
         if (cap_en && bus.ch_addr == bus.snd_addr)   snd_data = cap_data;
         if (bus.wb_en && bus.wb_addr == bus.snd_addr) snd_data = bus.wb_data;
      end
`endif
   end

   always_comb begin
      bus.pred_out = '0;
      bus.pred_vld = 1'b0;
      if (bus.rd_src == SEL_NONE_S) begin
         bus.pred_out = rd_data;
         bus.pred_vld = rd_vld;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (bus.rd_src == SW'(k) + SEL_BASE_S) begin
               bus.pred_out = bus.ch_in[k*PW +: PW];
               bus.pred_vld = 1'b1;
            end
         end
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      pred_send_lane #(.PW(PW)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (bus.snd_mask[k]),
         .data  (snd_data),
         .q     (ch_out_q[k*PW +: PW])
      );
   end

   assign bus.ch_out = ch_out_q;
   assign bus.occ    = occ_q;
   assign bus.coll   = coll_q;
endmodule

// File: tb/tb_pred_reg_file_p.sv
// Bench for pred_reg_file_p: directed scenarios then random traffic against an array-based model.
module tb_pred_reg_file_p;
   localparam int PW    = 4;
   localparam int DEPTH = 64;
   localparam int NCH   = 5;
   localparam int AW    = 6;
   localparam int SW    = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pred_reg_file_p_if #(.PW(PW), .DEPTH(DEPTH), .NCH(NCH)) bus ();

   pred_reg_file_p #(.PW(PW), .DEPTH(DEPTH), .NCH(NCH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [PW-1:0]     mdat   [DEPTH];
   bit                mvld   [DEPTH];
   bit                mknown [DEPTH];
   bit                mcoll;
   logic [NCH*PW-1:0] mout;
   int                total  = 0;
   int                passed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int popc();
      int n = 0;
      foreach (mvld[i]) n += int'(mvld[i]);
      return n;
   endfunction

   task automatic idle();
      bus.ch_in    = '0;
      bus.ch_sel   = '0;
      bus.ch_addr  = '0;
      bus.wb_en    = 1'b0;
      bus.wb_addr  = '0;
      bus.wb_data  = '0;
      bus.rd_src   = '0;
      bus.rd_addr  = '0;
      bus.snd_addr = '0;
      bus.snd_mask = '0;
      bus.clr      = 1'b0;
   endtask

   // Reset asserted mid-cycle so the clearing has to be asynchronous.
   task automatic do_reset();
      idle();
      #2 rst_n = 1'b0;
      #1;
      foreach (mvld[i]) mvld[i] = 1'b0;
      mcoll = 1'b0;
      mout  = '0;
      chk("rst_occ",    32'(bus.occ),    32'(0));
      chk("rst_coll",   32'(bus.coll),   32'(0));
      chk("rst_ch_out", 32'(bus.ch_out), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock with current inputs: check the combinational read, advance model, check registered outputs.
   task automatic cycle();
      int cs, rs, ra, sa, ca, wa;
      bit cap, rv_exp, rd_known;
      logic [PW-1:0] cdat, rd_exp, sv;
      logic [NCH*PW-1:0] out_exp;
      #1;
      cs  = int'(bus.ch_sel);
      ca  = int'(bus.ch_addr);
      wa  = int'(bus.wb_addr);
      cap = (cs >= 1 && cs <= NCH);
      cdat = '0;
      if (cap) cdat = PW'(bus.ch_in >> ((cs - 1) * PW));

      rs = int'(bus.rd_src);
      ra = int'(bus.rd_addr);
      rd_exp = '0; rv_exp = 1'b0; rd_known = 1'b1;
      if (rs == 0) begin
         rd_exp = mdat[ra]; rv_exp = mvld[ra]; rd_known = mknown[ra];
`ifdef PRED_BYPASS_EN
         if (!bus.clr && cap && ca == ra) begin
            rd_exp = cdat; rv_exp = 1'b1; rd_known = 1'b1;
         end
         if (!bus.clr && bus.wb_en && wa == ra) begin
            rd_exp = bus.wb_data; rv_exp = 1'b1; rd_known = 1'b1;
         end
`endif
      end else if (rs <= NCH) begin
         rd_exp = PW'(bus.ch_in >> ((rs - 1) * PW));
         rv_exp = 1'b1;
      end
      if (rd_known) chk("pred_out", 32'(bus.pred_out), 32'(rd_exp));
      chk("pred_vld", 32'(bus.pred_vld), 32'(rv_exp));

      sa = int'(bus.snd_addr);
      sv = mvld[sa] ? mdat[sa] : '0;
`ifdef PRED_BYPASS_EN
      if (!bus.clr && cap && ca == sa) sv = cdat;
      if (!bus.clr && bus.wb_en && wa == sa) sv = bus.wb_data;
`endif
      out_exp = '0;
      for (int k = 0; k < NCH; k++)
         if (bus.snd_mask[k]) out_exp[k*PW +: PW] = sv;

      if (bus.clr) begin
         foreach (mvld[i]) mvld[i] = 1'b0;
      end else begin
         if (cap) begin
            mdat[ca] = cdat; mvld[ca] = 1'b1; mknown[ca] = 1'b1;
         end
         if (bus.wb_en) begin
            mdat[wa] = bus.wb_data; mvld[wa] = 1'b1; mknown[wa] = 1'b1;
         end
         if (cap && bus.wb_en && ca == wa) mcoll = 1'b1;
      end
      mout = out_exp;

      @(posedge clk);
      #1;
      chk("occ",    32'(bus.occ),    32'(popc()));
      chk("coll",   32'(bus.coll),   32'(mcoll));
      chk("ch_out", 32'(bus.ch_out), 32'(mout));
   endtask

   initial begin
      foreach (mknown[i]) mknown[i] = 1'b0;
      foreach (mvld[i])   mvld[i]   = 1'b0;
      mcoll = 1'b0;
      mout  = '0;

      // Reset state and an unwritten read.
      do_reset();
      bus.rd_src  = '0;
      bus.rd_addr = AW'(5);
      #1;
      chk("r036_vld", 32'(bus.pred_vld), 32'(0));
      cycle();

      // Capture from channel 1, then send to lanes 0 and 4.
      idle();
      bus.ch_in   = 20'h000A0;
      bus.ch_sel  = SW'(2);
      bus.ch_addr = AW'(7);
      cycle();
      idle();
      bus.snd_addr = AW'(7);
      bus.snd_mask = 5'b10001;
      cycle();
      chk("r037_ch_out", 32'(bus.ch_out), 32'h000A000A);
      chk("r037_occ",    32'(bus.occ),    32'(1));

      // Capture and write-back collide on address 9.
      do_reset();
      bus.ch_in   = 20'h00003;
      bus.ch_sel  = SW'(1);
      bus.ch_addr = AW'(9);
      bus.wb_en   = 1'b1;
      bus.wb_addr = AW'(9);
      bus.wb_data = 4'hC;
      cycle();
      idle();
      bus.rd_addr = AW'(9);
      #1;
      chk("r038_data", 32'(bus.pred_out), 32'hC);
      chk("r038_coll", 32'(bus.coll),     32'(1));
      chk("r038_occ",  32'(bus.occ),      32'(1));
      cycle();

      // Fill every entry, then rewrite one: occupancy holds at DEPTH.
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         idle();
         bus.wb_en   = 1'b1;
         bus.wb_addr = AW'(i);
         bus.wb_data = PW'(i);
         cycle();
      end
      idle();
      bus.wb_en   = 1'b1;
      bus.wb_addr = AW'(0);
      bus.wb_data = 4'hF;
      cycle();
      chk("r039_occ_full", 32'(bus.occ), 32'(DEPTH));
      idle();
      cycle();
      chk("r039_occ_hold", 32'(bus.occ), 32'(DEPTH));

      // Clear beats a simultaneous write; data survives the clear.
      idle();
      bus.clr     = 1'b1;
      bus.wb_en   = 1'b1;
      bus.wb_addr = AW'(3);
      bus.wb_data = 4'h9;
      cycle();
      chk("r040_occ", 32'(bus.occ), 32'(0));
      idle();
      bus.rd_addr = AW'(3);
      #1;
      chk("r040_vld3",  32'(bus.pred_vld), 32'(0));
      chk("r040_data3", 32'(bus.pred_out), 32'h3);
      bus.rd_addr = AW'(10);
      #1;
      chk("r040_data10", 32'(bus.pred_out), 32'hA);
      cycle();
      idle();
      bus.wb_en   = 1'b1;
      bus.wb_addr = AW'(3);
      bus.wb_data = 4'h5;
      cycle();
      idle();
      bus.rd_addr = AW'(3);
      #1;
      chk("r040_reread", 32'(bus.pred_out), 32'h5);
      chk("r040_revld",  32'(bus.pred_vld), 32'(1));
      cycle();

      // Read of an address being written in the same cycle.
      idle();
      bus.wb_en   = 1'b1;
      bus.wb_addr = AW'(4);
      bus.wb_data = 4'h6;
      bus.rd_addr = AW'(4);
      #1;
`ifdef PRED_BYPASS_EN
      chk("r041_data", 32'(bus.pred_out), 32'h6);
      chk("r041_vld",  32'(bus.pred_vld), 32'(1));
`else
      chk("r041_data", 32'(bus.pred_out), 32'h4);
      chk("r041_vld",  32'(bus.pred_vld), 32'(0));
`endif
      cycle();

      // Random traffic over a small address window to provoke collisions and hits.
      for (int n = 0; n < 300; n++) begin
         if (n == 150) do_reset();
         bus.ch_in    = (NCH*PW)'($urandom);
         bus.ch_sel   = SW'($urandom_range(0, 7));
         bus.ch_addr  = AW'($urandom_range(0, 15));
         bus.wb_en    = 1'($urandom_range(0, 1));
         bus.wb_addr  = AW'($urandom_range(0, 15));
         bus.wb_data  = PW'($urandom);
         bus.rd_src   = ($urandom_range(0, 1) == 0) ? SW'(0) : SW'($urandom_range(1, 7));
         bus.rd_addr  = AW'($urandom_range(0, 15));
         bus.snd_addr = AW'($urandom_range(0, 15));
         bus.snd_mask = NCH'($urandom);
         bus.clr      = ($urandom_range(0, 31) == 0);
         cycle();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
